// File: rtl/da_rom_loader.sv
// Streams distributed-arithmetic partial-sum words for 8 ROMs x 256 entries into the da block.
// Optional macro DA_LOADER_SAT_EN: clamp each word to the ROM_W range and add the sat_flag output.
module da_rom_loader #(
    parameter int COEF_W = 20,
    parameter int ROM_W  = 20
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     coef_we,
    input  logic [5:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_in,
    input  logic                     go,
    input  logic                     pause,
    output logic [10:0]              CADDR,
    output logic signed [ROM_W-1:0]  CIN,
    output logic                     CLOAD,
    output logic                     valid_in,
    output logic                     busy,
`ifdef DA_LOADER_SAT_EN
    output logic                     done,
    output logic                     sat_flag
`else
    output logic                     done
`endif
);

    // state  | meaning
    // S_IDLE | coefficient writes accepted, waiting for go
    // S_LOAD | one ROM word per unpaused cycle, addresses 0..2047
    // S_DONE | single cycle that raises done and applies a deferred write
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef DA_LOADER_SAT_EN
    localparam int SUM_W = COEF_W + 3;
    localparam int ACC_W = (ROM_W > SUM_W) ? ROM_W : SUM_W;
`else
    // Wrapping a full-precision sum to ROM_W bits equals summing modulo 2^ROM_W.
    localparam int ACC_W = ROM_W;
`endif

    state_t                    state_q, state_d;
    logic [10:0]               cnt_q, cnt_d;
    logic signed [COEF_W-1:0]  coef_q [64];
    logic signed [COEF_W-1:0]  coef_d [64];
    logic                      pend_vld_q, pend_vld_d;
    logic [5:0]                pend_addr_q, pend_addr_d;
    logic signed [COEF_W-1:0]  pend_data_q, pend_data_d;
    logic [10:0]               caddr_q, caddr_d;
    logic signed [ROM_W-1:0]   cin_q, cin_d;
    logic                      cload_q, cload_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic signed [ACC_W-1:0]   acc;
    logic signed [COEF_W-1:0]  c_sel;
    logic signed [ROM_W-1:0]   word;

    always_comb begin
        acc   = '0;
        c_sel = '0;
        for (int j = 0; j < 8; j++) begin
            c_sel = coef_q[{cnt_q[10:8], 3'(j)}];
            if (cnt_q[j]) begin
                acc = acc + ACC_W'(c_sel);
            end
        end
    end

`ifdef DA_LOADER_SAT_EN
    logic sat_q, sat_d;
    logic word_clamped;

    generate
        if (ACC_W > ROM_W) begin : g_sat
            localparam logic signed [ACC_W-1:0] W_MAX =
                {{(ACC_W-ROM_W+1){1'b0}}, {(ROM_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] W_MIN =
                {{(ACC_W-ROM_W+1){1'b1}}, {(ROM_W-1){1'b0}}};

            always_comb begin
                word         = acc[ROM_W-1:0];
                word_clamped = 1'b0;
                if (acc > W_MAX) begin
                    word         = W_MAX[ROM_W-1:0];
                    word_clamped = 1'b1;
                end else if (acc < W_MIN) begin
                    word         = W_MIN[ROM_W-1:0];
                    word_clamped = 1'b1;
                end
            end
        end else begin : g_nosat
            assign word         = acc;
            assign word_clamped = 1'b0;
        end
    endgenerate
`else
    assign word = acc;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coef_d      = coef_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        caddr_d     = '0;
        cin_d       = '0;
        cload_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
`ifdef DA_LOADER_SAT_EN
        sat_d       = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A write coinciding with go is parked so this load sees the old table.
                if (coef_we) begin
                    if (go) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = coef_addr;
                        pend_data_d = coef_in;
                    end else begin
                        coef_d[coef_addr] = coef_in;
                    end
                end
                if (go) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
`ifdef DA_LOADER_SAT_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                busy_d = 1'b1;
                if (pause) begin
                    caddr_d = caddr_q;
                    cin_d   = cin_q;
                end else begin
                    caddr_d = cnt_q;
                    cin_d   = word;
                    cload_d = 1'b1;
                    cnt_d   = cnt_q + 11'd1;
`ifdef DA_LOADER_SAT_EN
                    if (word_clamped) begin
                        sat_d = 1'b1;
                    end
`endif
                    if (cnt_q == 11'h7FF) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (pend_vld_q) begin
                    coef_d[pend_addr_q] = pend_data_q;
                    pend_vld_d          = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            for (int i = 0; i < 64; i++) begin
                coef_q[i] <= '0;
            end
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            caddr_q     <= '0;
            cin_q       <= '0;
            cload_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coef_q      <= coef_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            caddr_q     <= caddr_d;
            cin_q       <= cin_d;
            cload_q     <= cload_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef DA_LOADER_SAT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`endif

    assign CADDR    = caddr_q;
    assign CIN      = cin_q;
    assign CLOAD    = cload_q;
    assign valid_in = cload_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_da_rom_loader.sv
// Scoreboard bench for da_rom_loader: a coefficient model predicts every streamed word.
module tb_da_rom_loader;

    localparam int COEF_W = 20;
    localparam int ROM_W  = 20;
`ifdef DA_LOADER_SAT_EN
    localparam longint ROM_MAX = (longint'(1) <<< (ROM_W-1)) - 1;
    localparam longint ROM_MIN = -(longint'(1) <<< (ROM_W-1));
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic              coef_we;
    logic [5:0]        coef_addr;
    logic [COEF_W-1:0] coef_in;
    logic              go;
    logic              pause;
    logic [10:0]       CADDR;
    logic [ROM_W-1:0]  CIN;
    logic              CLOAD;
    logic              valid_in;
    logic              busy;
    logic              done;
`ifdef DA_LOADER_SAT_EN
    logic              sat_flag;
    logic              exp_sat;
`endif

    int errors = 0;
    int checks = 0;

    int model_coef [64];
    logic [30:0] exp_q [$];
    logic [30:0] obs_q [$];
    logic [ROM_W-1:0] obs_mem [2048];

    int done_cyc, done_cnt, cload_cnt, gap_cnt, hold_bad, overlap_cnt, vbad;
    bit aborted;

    da_rom_loader #(.COEF_W(COEF_W), .ROM_W(ROM_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_in   (coef_in),
        .go        (go),
        .pause     (pause),
        .CADDR     (CADDR),
        .CIN       (CIN),
        .CLOAD     (CLOAD),
        .valid_in  (valid_in),
        .busy      (busy),
`ifdef DA_LOADER_SAT_EN
        .done      (done),
        .sat_flag  (sat_flag)
`else
        .done      (done)
`endif
    );

    always #5 clk = ~clk;

    function automatic longint model_sum(input int a);
        longint s;
        int     g;
        s = 0;
        g = a >> 8;
        for (int j = 0; j < 8; j++) begin
            if (a[j]) s += longint'(model_coef[g*8 + j]);
        end
        return s;
    endfunction

    function automatic logic [ROM_W-1:0] model_word(input int a);
        longint s;
        s = model_sum(a);
`ifdef DA_LOADER_SAT_EN
        if (s > ROM_MAX) s = ROM_MAX;
        else if (s < ROM_MIN) s = ROM_MIN;
`endif
        return s[ROM_W-1:0];
    endfunction

    task automatic push_expected();
        exp_q.delete();
`ifdef DA_LOADER_SAT_EN
        exp_sat = 1'b0;
`endif
        for (int a = 0; a < 2048; a++) begin
            exp_q.push_back({11'(a), model_word(a)});
`ifdef DA_LOADER_SAT_EN
            if (model_sum(a) > ROM_MAX || model_sum(a) < ROM_MIN) exp_sat = 1'b1;
`endif
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 6'(addr);
        coef_in   = COEF_W'(val);
        @(negedge clk);
        coef_we   = 1'b0;
        model_coef[addr] = val;
    endtask

    // Drives go (optionally with a same-cycle write) and records the stream; no checking here.
    task automatic run_load(input int pause_at, input int pause_len, input bit poke,
                            input bit wr_go, input int wr_addr, input int wr_val,
                            input int abort_at);
        int n, pause_left;
        bit pause_done, finished;
        logic [10:0] held_addr;
        logic [ROM_W-1:0] held_data;
        obs_q.delete();
        for (int a = 0; a < 2048; a++) obs_mem[a] = 'x;
        done_cyc = -1; done_cnt = 0; cload_cnt = 0; gap_cnt = 0;
        hold_bad = 0; overlap_cnt = 0; vbad = 0; aborted = 1'b0;
        held_addr = '0; held_data = '0;
        go = 1'b1;
        if (wr_go) begin
            coef_we   = 1'b1;
            coef_addr = 6'(wr_addr);
            coef_in   = COEF_W'(wr_val);
        end
        @(posedge clk);
        #1;
        go = 1'b0;
        coef_we = 1'b0;
        n = 0; pause_left = 0; pause_done = 1'b0; finished = 1'b0;
        while (!finished) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy && !CLOAD) begin
                gap_cnt++;
                if (CADDR !== held_addr || CIN !== held_data) hold_bad++;
            end
            if (CLOAD) begin
                cload_cnt++;
                obs_q.push_back({CADDR, CIN});
                obs_mem[CADDR] = CIN;
                held_addr = CADDR;
                held_data = CIN;
            end
            if (CLOAD !== valid_in) vbad++;
            if (busy && done) overlap_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) pause = 1'b0;
            end else if (!pause_done && CLOAD && int'(CADDR) == pause_at) begin
                pause = 1'b1;
                pause_left = pause_len;
                pause_done = 1'b1;
            end
            if (poke && n == 10) begin
                go = 1'b1; coef_we = 1'b1; coef_addr = 6'd1; coef_in = COEF_W'(99);
            end
            if (poke && n == 11) begin
                go = 1'b0; coef_we = 1'b0;
            end
            if (abort_at >= 0 && CLOAD && int'(CADDR) == abort_at) begin
                aborted = 1'b1;
                finished = 1'b1;
            end
            if (done_cyc >= 0 && n >= done_cyc + 2) finished = 1'b1;
            if (n > 3000) finished = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_in = '0; go = 1'b0; pause = 1'b0;
        for (int i = 0; i < 64; i++) model_coef[i] = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (CADDR !== 11'd0) begin errors++; $display("FAIL reset_caddr got=%h exp=0", CADDR); end
        checks++; if (CIN !== '0) begin errors++; $display("FAIL reset_cin got=%h exp=0", CIN); end
        checks++; if (CLOAD !== 1'b0) begin errors++; $display("FAIL reset_cload got=%b exp=0", CLOAD); end
        checks++; if (valid_in !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_zero_load();
        logic [30:0] e, o;
        push_expected();
        run_load(-1, 0, 1'b0, 1'b0, 0, 0, -1);
        checks++; if (cload_cnt !== 2048) begin errors++; $display("FAIL zero_cload_count got=%0d exp=2048", cload_cnt); end
        checks++; if (done_cyc !== 2049) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=2049", done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL zero_busy_done_overlap got=%0d exp=0", overlap_cnt); end
        checks++; if (vbad !== 0) begin errors++; $display("FAIL zero_valid_vs_cload got=%0d exp=0", vbad); end
        checks++; if ({CADDR, CIN, CLOAD, busy, done} !== '0) begin
            errors++; $display("FAIL zero_idle_outputs got=%h/%h/%b/%b/%b exp=0", CADDR, CIN, CLOAD, busy, done);
        end
`ifdef DA_LOADER_SAT_EN
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL zero_sat_flag got=%b exp=0", sat_flag); end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL zero_stream got=none exp=%h", e); exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL zero_stream got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_pattern();
        logic [30:0] e, o;
        write_coef(0, 5);
        write_coef(1, -3);
        push_expected();
        run_load(-1, 0, 1'b0, 1'b0, 0, 0, -1);
        checks++; if (obs_mem[1] !== ROM_W'(5)) begin errors++; $display("FAIL pat_addr1 got=%h exp=5", obs_mem[1]); end
        checks++; if (obs_mem[2] !== ROM_W'(-3)) begin errors++; $display("FAIL pat_addr2 got=%h exp=-3", obs_mem[2]); end
        checks++; if (obs_mem[3] !== ROM_W'(2)) begin errors++; $display("FAIL pat_addr3 got=%h exp=2", obs_mem[3]); end
        checks++; if (obs_mem[255] !== ROM_W'(2)) begin errors++; $display("FAIL pat_addr255 got=%h exp=2", obs_mem[255]); end
        checks++; if (obs_mem[256] !== ROM_W'(0)) begin errors++; $display("FAIL pat_addr256 got=%h exp=0", obs_mem[256]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL pat_stream got=none exp=%h", e); exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL pat_stream got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_group7();
        logic [30:0] e, o;
        for (int j = 0; j < 8; j++) write_coef(56 + j, j + 1);
        push_expected();
        run_load(-1, 0, 1'b0, 1'b0, 0, 0, -1);
        checks++; if (obs_mem[11'h7FF] !== ROM_W'(36)) begin errors++; $display("FAIL g7_7ff got=%h exp=36", obs_mem[11'h7FF]); end
        checks++; if (obs_mem[11'h701] !== ROM_W'(1)) begin errors++; $display("FAIL g7_701 got=%h exp=1", obs_mem[11'h701]); end
        checks++; if (obs_mem[11'h780] !== ROM_W'(8)) begin errors++; $display("FAIL g7_780 got=%h exp=8", obs_mem[11'h780]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL g7_stream got=none exp=%h", e); exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL g7_stream got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [30:0] e, o;
        for (int j = 0; j < 8; j++) write_coef(j, 524287);
        push_expected();
        run_load(-1, 0, 1'b0, 1'b0, 0, 0, -1);
`ifdef DA_LOADER_SAT_EN
        checks++; if (obs_mem[255] !== ROM_W'(524287)) begin errors++; $display("FAIL sat_addr255 got=%h exp=524287", obs_mem[255]); end
        checks++; if (sat_flag !== exp_sat) begin errors++; $display("FAIL sat_flag got=%b exp=%b", sat_flag, exp_sat); end
`else
        checks++; if (obs_mem[255] !== ROM_W'(-8)) begin errors++; $display("FAIL wrap_addr255 got=%h exp=-8", obs_mem[255]); end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL wrap_stream got=none exp=%h", e); exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL wrap_stream got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_pause();
        logic [30:0] e, o;
        push_expected();
        run_load(100, 3, 1'b1, 1'b0, 0, 0, -1);
        checks++; if (gap_cnt !== 3) begin errors++; $display("FAIL pause_gap got=%0d exp=3", gap_cnt); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL pause_hold got=%0d exp=0", hold_bad); end
        checks++; if (done_cyc !== 2052) begin errors++; $display("FAIL pause_done_cycle got=%0d exp=2052", done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL pause_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (cload_cnt !== 2048) begin errors++; $display("FAIL pause_cload_count got=%0d exp=2048", cload_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL pause_stream got=none exp=%h", e); exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL pause_stream got=%h exp=%h", o, e); end
            end
        end
    endtask

    // Also confirms the go/write poked during the paused load left the table alone.
    task automatic test_back_to_back();
        logic [30:0] e, o;
        push_expected();
        run_load(-1, 0, 1'b0, 1'b1, 1, 9, -1);
        checks++; if (obs_mem[2] !== ROM_W'(524287)) begin errors++; $display("FAIL b2b_first_addr2 got=%h exp=524287", obs_mem[2]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL b2b_first_stream got=none exp=%h", e); exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_first_stream got=%h exp=%h", o, e); end
            end
        end
        model_coef[1] = 9;
        push_expected();
        run_load(-1, 0, 1'b0, 1'b0, 0, 0, -1);
        checks++; if (obs_mem[2] !== ROM_W'(9)) begin errors++; $display("FAIL b2b_second_addr2 got=%h exp=9", obs_mem[2]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL b2b_second_stream got=none exp=%h", e); exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_second_stream got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [30:0] e, o;
        exp_q.delete();
        run_load(-1, 0, 1'b0, 1'b0, 0, 0, 500);
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL rst_reach_500 got=%b exp=1", aborted); end
        resetn = 1'b0;
        #1;
        checks++; if ({CADDR, CIN, CLOAD, valid_in, busy, done} !== '0) begin
            errors++; $display("FAIL rst_async_outputs got=%h/%h/%b/%b/%b/%b exp=0", CADDR, CIN, CLOAD, valid_in, busy, done);
        end
        for (int i = 0; i < 64; i++) model_coef[i] = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        push_expected();
        run_load(-1, 0, 1'b0, 1'b0, 0, 0, -1);
        checks++; if (obs_mem[255] !== ROM_W'(0)) begin errors++; $display("FAIL rst_cleared_addr255 got=%h exp=0", obs_mem[255]); end
        checks++; if (done_cyc !== 2049) begin errors++; $display("FAIL rst_done_cycle got=%0d exp=2049", done_cyc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL rst_stream got=none exp=%h", e); exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL rst_stream got=%h exp=%h", o, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_load();
        test_pattern();
        test_group7();
        test_wrap();
        test_pause();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/da_rom_loader.md
# da_rom_loader

Initiator side of the DA coefficient-ROM load interface. It holds 64 FIR tap coefficients, 8 groups of 8. On command it computes every distributed-arithmetic partial-sum word for the 8 ROMs, 256 entries each, and streams them into the `da` block over its `CADDR`/`CIN`/`CLOAD`/`valid_in` port, one word per clock. It sits between the host/coefficient register path and the `da` datapath, and replaces bench-driven ROM preloading.

## Interface
- `COEF_W`, default 20: signed coefficient width.
- `ROM_W`, default 20: signed ROM word width. Must equal the `da` CIN width.
- `clk` in 1: system clock. Everything is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in 6: coefficient index. Bits [5:3] are the group g and bits [2:0] are the tap j.
- `coef_in` in `COEF_W`: signed coefficient value.
- `go` in 1: single-cycle start pulse.
- `pause` in 1: stalls the stream while high.
- `CADDR` out 11: ROM word address. Bits [10:8] select the ROM and bits [7:0] are the entry.
- `CIN` out `ROM_W`: signed ROM word.
- `CLOAD` out 1: load strobe.
- `valid_in` out 1: word valid. Always identical to `CLOAD`.
- `busy` out 1: high during the LOAD state.
- `done` out 1: one-cycle pulse after the last word.

## Operation
- The coefficient file is 64 x `COEF_W` registers. A write happens when `coef_we`=1 in IDLE. Writes in LOAD or DONE are ignored.
- ROM content rule: word(g, k) = Σ_{j=0..7} k[j] ? coef[8g+j] : 0.
  - The sum uses signed arithmetic at `COEF_W`+3 bits.
  - It is then narrowed to `ROM_W`.
  - Entry k=0 is always 0.
- Narrowing: the result wraps, keeping the low `ROM_W` bits. The saturating alternative is under Configuration.
- Address order is ascending, 0 to 2047. ROM0 entries 0..255 come first, then ROM1, and so on through ROM7.
- FSM states:
  - IDLE to LOAD on `go`=1.
  - LOAD to DONE after word 2047 has been presented.
  - DONE to IDLE unconditionally after one cycle.
- `go` in LOAD or DONE is ignored. No restart and no queuing.
- `pause`=1 in LOAD:
  - `CLOAD` and `valid_in` are 0 that cycle.
  - The address counter holds.
  - `CADDR` and `CIN` hold the last presented values.
  - When `pause` falls, the stream resumes at the next unpresented address. No word is skipped and none is duplicated.
- Outside LOAD, `CADDR`=0, `CIN`=0, `CLOAD`=0 and `valid_in`=0.

## Timing
- Reset values:
  - State is IDLE.
  - `CADDR`=0, `CIN`=0, `CLOAD`=0, `valid_in`=0, `busy`=0, `done`=0.
  - All 64 coefficients are cleared to 0.
- A coefficient write at edge T is visible to a `go` sampled at edge T+1.
- `go` sampled at edge T:
  - After edge T+1, `busy`=1 and word 0 is presented with `CLOAD`=1.
  - Word k is presented after edge T+1+k, provided there are no pauses.
- Word 2047 is presented after edge T+2048.
- After edge T+2049:
  - `CLOAD`=0 and `busy`=0.
  - `done`=1 for exactly one cycle.
- `busy` and `done` are never high together.
- Every output is registered, so output changes align with `clk` rising edges. `da` samples these outputs on its own clock.
- Each cycle with `pause`=1 in LOAD adds exactly one cycle to the total load time.
- `pause` in IDLE or DONE has no effect.
- Reset during LOAD: all outputs go to reset values immediately, without waiting for a clock edge. The coefficients are lost, and no `done` is produced.
- `go` and `coef_we` in the same IDLE cycle: the write commits, but the new coefficient first appears in a later load, not this one.

## Configuration
- `DA_LOADER_SAT_EN` defined:
  - Each word is clamped to [-2^(ROM_W-1), 2^(ROM_W-1)-1] before it is output.
  - An extra output `sat_flag` (1 bit) goes high after the first clamped word of a load and stays high until the next `go` or reset.
- Not defined: two's-complement wrap, and no `sat_flag` port.

## Test plan
- All coefficients 0, then `go`:
  - Exactly 2048 `CLOAD` cycles appear with `CADDR` 0..2047 in order and every `CIN`=0.
  - `done` pulses once, 2049 cycles after the `go` edge.
- Set coef[0]=5 and coef[1]=-3, then `go`:
  - `CADDR`=1 gives `CIN`=5.
  - `CADDR`=2 gives -3.
  - `CADDR`=3 gives 2.
  - `CADDR`=255 gives 2.
  - `CADDR`=256 gives 0.
- Set coef[56..63]=1..8:
  - `CADDR`=0x7FF gives 36.
  - `CADDR`=0x701 gives 1.
  - `CADDR`=0x780 gives 8.
- Set coef[0..7]=524287:
  - `CADDR`=255 gives -8 in wrap mode.
  - With `DA_LOADER_SAT_EN`, it gives 524287 and `sat_flag`=1.
- Assert `pause` for 3 cycles at `CADDR`=100:
  - `CLOAD`=0 for those 3 cycles, then word 101 follows.
  - `done` arrives 2052 cycles after `go`.
  - `go` and `coef_we` applied during the load are ignored.
- Drop `resetn` at `CADDR`=500:
  - All outputs go to 0 asynchronously and the coefficients are cleared.
  - After release, a `go` streams all-zero words.
